// File: rtl/wagu_fc_pe.sv
// Weight-address generator for fully-connected layers: streams one group of
// GROUP_NUM weight words per input tile and rotates a one-hot PE enable.
// Optional bias fetch per output piece when WAGU_FC_BIAS_EN is defined.
module wagu_fc_pe #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned PIECE_W   = 8,
  parameter int unsigned GROUP_NUM = 32,
  parameter int unsigned PE_NUM    = 8,
  parameter logic [3:0]  FC_MODE   = 4'd2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_calculate,
  input  logic [3:0]         mode,
  input  logic               feature_load_end,
  input  logic [ADDR_W-1:0]  addr_start_w,
  input  logic [PIECE_W-1:0] in_piece,
  input  logic [PIECE_W-1:0] out_piece,
  input  logic               w_ready,
`ifdef WAGU_FC_BIAS_EN
  input  logic [ADDR_W-1:0]  addr_bias,
  output logic               o_bias_rd,
`endif
  output logic [ADDR_W-1:0]  o_w_addr,
  output logic               o_rd_en,
  output logic               o_group_end,
  output logic [PE_NUM-1:0]  o_pe_en,
  output logic               o_fc_out,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned GW = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GROUP_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FEAT,
    ADDR_GEN,
    JUDGE,
    UPDATE
`ifdef WAGU_FC_BIAS_EN
    , BIAS
`endif
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  w_addr;
  logic [GW-1:0]      group_cnt;
  logic [PIECE_W-1:0] in_cnt, out_cnt;
  logic [PIECE_W-1:0] in_last, out_last;
  logic [PE_NUM-1:0]  pe_en;
  logic [PE_NUM-1:0]  pe_rot;
  logic               in_end, out_end;

  assign in_end  = (in_cnt == in_last);
  assign out_end = (out_cnt == out_last);

  // Rotate left by one; doubling the vector keeps PE_NUM==1 well-formed.
  always_comb begin
    pe_rot = PE_NUM'({pe_en, pe_en} >> (PE_NUM - 1));
  end

  assign o_rd_en     = (state == ADDR_GEN);
  assign o_group_end = o_rd_en && w_ready && (group_cnt == G_LAST);
  assign o_fc_out    = (state == JUDGE) && in_end;
  assign o_busy      = (state != IDLE);
  assign o_pe_en     = pe_en;

`ifdef WAGU_FC_BIAS_EN
  assign o_bias_rd = (state == BIAS);
  assign o_done    = o_bias_rd && w_ready && out_end;
  // Bias address is muxed onto the read port so the weight pointer survives.
  assign o_w_addr  = o_bias_rd ? (addr_bias + ADDR_W'(out_cnt)) : w_addr;
`else
  assign o_done    = o_fc_out && out_end;
  assign o_w_addr  = w_addr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      w_addr    <= '0;
      group_cnt <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      in_last   <= '0;
      out_last  <= '0;
      pe_en     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_calculate && (mode == FC_MODE)) begin
            w_addr    <= addr_start_w;
            in_last   <= (in_piece  == '0) ? '0 : in_piece  - PIECE_W'(1);
            out_last  <= (out_piece == '0) ? '0 : out_piece - PIECE_W'(1);
            group_cnt <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            pe_en     <= PE_NUM'(1);
            state     <= WAIT_FEAT;
          end
        end
        WAIT_FEAT: begin
          if (feature_load_end) state <= ADDR_GEN;
        end
        ADDR_GEN: begin
          if (w_ready) begin
            w_addr <= w_addr + ADDR_W'(1);
            if (group_cnt == G_LAST) begin
              group_cnt <= '0;
              state     <= JUDGE;
            end else begin
              group_cnt <= group_cnt + GW'(1);
            end
          end
        end
        JUDGE: begin
          if (in_end) pe_en <= pe_rot;
`ifdef WAGU_FC_BIAS_EN
          state <= in_end ? BIAS : UPDATE;
`else
          state <= (in_end && out_end) ? IDLE : UPDATE;
`endif
        end
        UPDATE: begin
          if (in_end) begin
            in_cnt  <= '0;
            out_cnt <= out_cnt + PIECE_W'(1);
          end else begin
            in_cnt <= in_cnt + PIECE_W'(1);
          end
          state <= WAIT_FEAT;
        end
`ifdef WAGU_FC_BIAS_EN
        BIAS: begin
          if (w_ready) state <= out_end ? IDLE : UPDATE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wagu_fc_pe.sv
// Bench for wagu_fc_pe: table of layer configurations checked beat-by-beat
// against an address-list model, plus hand sequences for reset and idle cases.
module tb_wagu_fc_pe;
  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned PIECE_W = 8;
  localparam int unsigned G       = 32;
  localparam int unsigned PE      = 8;

  logic               clk, rst, start_calculate, feature_load_end, w_ready;
  logic [3:0]         mode;
  logic [ADDR_W-1:0]  addr_start_w, addr_bias;
  logic [PIECE_W-1:0] in_piece, out_piece;
  logic [ADDR_W-1:0]  o_w_addr;
  logic               o_rd_en, o_group_end, o_fc_out, o_busy, o_done, bias_rd;
  logic [PE-1:0]      o_pe_en;

  wagu_fc_pe #(
    .ADDR_W(ADDR_W), .PIECE_W(PIECE_W), .GROUP_NUM(G), .PE_NUM(PE), .FC_MODE(4'd2)
  ) dut (
    .clk(clk), .rst(rst), .start_calculate(start_calculate), .mode(mode),
    .feature_load_end(feature_load_end), .addr_start_w(addr_start_w),
    .in_piece(in_piece), .out_piece(out_piece), .w_ready(w_ready),
`ifdef WAGU_FC_BIAS_EN
    .addr_bias(addr_bias), .o_bias_rd(bias_rd),
`endif
    .o_w_addr(o_w_addr), .o_rd_en(o_rd_en), .o_group_end(o_group_end),
    .o_pe_en(o_pe_en), .o_fc_out(o_fc_out), .o_busy(o_busy), .o_done(o_done)
  );

`ifndef WAGU_FC_BIAS_EN
  assign bias_rd = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(o_w_addr), 0);
    check({tag, "_rd"}, 32'(o_rd_en), 0);
    check({tag, "_gend"}, 32'(o_group_end), 0);
    check({tag, "_pe"}, 32'(o_pe_en), 0);
    check({tag, "_fc"}, 32'(o_fc_out), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_bias"}, 32'(bias_rd), 0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int unsigned       inp;
    int unsigned       outp;
    int                rdy;       // 0 always, 1 pattern 1,0,0,1, 2 random
    int                feat;      // 0 always high, 1 random
    bit                timed;
    bit                poke;      // restart attempt + limit change mid-layer
    int unsigned       exp_beats;
    logic [PE-1:0]     exp_pe;
  } vec_t;

  task automatic run_layer(input vec_t v);
    int unsigned ie, oe, n, done_k, budget, beats, fc;
    logic [ADDR_W-1:0] eq[$];
    bit ek[$];
    bit done, kind, ge_exp;
    int first_rd;
    logic [PE-1:0] pe_exp;
    ie = (v.inp == 0) ? 1 : v.inp;
    oe = (v.outp == 0) ? 1 : v.outp;
    n  = ie * oe;
    // Expected read stream: contiguous weight words, one bias word per output piece
    for (int unsigned o = 0; o < oe; o++) begin
      for (int unsigned i = 0; i < ie; i++)
        for (int unsigned b = 0; b < G; b++) begin
          eq.push_back(v.addr + ADDR_W'((o * ie + i) * G + b));
          ek.push_back(1'b0);
        end
`ifdef WAGU_FC_BIAS_EN
      eq.push_back(addr_bias + ADDR_W'(o));
      ek.push_back(1'b1);
`endif
    end
    done_k = (n - 1) * (G + 3) + G + 1;
`ifdef WAGU_FC_BIAS_EN
    done_k += oe;
`endif
    budget = 8 * n * (G + 4) + 100;

    addr_start_w = v.addr; in_piece = PIECE_W'(v.inp); out_piece = PIECE_W'(v.outp);
    mode = 4'd2; start_calculate = 1'b1; feature_load_end = 1'b0; w_ready = 1'b0;
    @(posedge clk); #1;
    start_calculate = 1'b0;
    beats = 0; fc = 0; done = 1'b0; first_rd = -1;
    for (int k = 0; k < int'(budget) && !done; k++) begin
      feature_load_end = (v.feat == 0) ? 1'b1 : 1'($urandom % 2);
      case (v.rdy)
        0:       w_ready = 1'b1;
        1:       w_ready = (k % 4 == 0) || (k % 4 == 3);
        default: w_ready = ($urandom % 4) != 0;
      endcase
      start_calculate = v.poke && (k == 40);
      if (v.poke && k == 40) begin
        addr_start_w = 13'h555; in_piece = 8'd7; out_piece = 8'd5;
      end
      @(negedge clk);
      if ((o_rd_en || bias_rd) && w_ready) begin
        if (first_rd < 0) first_rd = k;
        if (eq.size() == 0) begin
          check("extra_read", 1, 0);
        end else begin
          kind = ek.pop_front();
          check("read_kind", {30'd0, bias_rd, o_rd_en}, kind ? 2 : 1);
          check("read_addr", 32'(o_w_addr), 32'(eq.pop_front()));
          ge_exp = !kind && (beats % G == G - 1);
          check("group_end", 32'(o_group_end), 32'(ge_exp));
          if (!kind) beats++;
        end
      end else begin
        check("group_end_idle", 32'(o_group_end), 0);
      end
      if (o_fc_out) begin
        fc++;
        check("fc_pos", beats, fc * ie * G);
        pe_exp = PE'(1) << ((fc - 1) % PE);
        check("fc_pe", 32'(o_pe_en), 32'(pe_exp));
      end
      if (o_done) begin
        done = 1'b1;
        check("done_left", eq.size(), 0);
        check("done_fc", fc, oe);
        if (v.timed) check("done_time", k, done_k);
      end
      @(posedge clk); #1;
    end
    start_calculate = 1'b0;
    if (!done) check("layer_timeout", 0, 1);
    if (v.timed) check("first_rd", first_rd, 1);
    check("busy_after", 32'(o_busy), 0);
    check("done_after", 32'(o_done), 0);
    check("pe_final", 32'(o_pe_en), 32'(v.exp_pe));
    check("beats", beats, v.exp_beats);
  endtask

  vec_t tbl[7];
  int acc;

  initial begin
    tbl[0] = '{13'h100,  1, 1, 0, 0, 1'b1, 1'b0,  32, 8'h02};
    tbl[1] = '{13'h000,  3, 2, 0, 0, 1'b1, 1'b0, 192, 8'h04};
    tbl[2] = '{13'h040,  1, 1, 1, 0, 1'b0, 1'b0,  32, 8'h02};
    tbl[3] = '{13'h200,  1, 9, 0, 0, 1'b1, 1'b1, 288, 8'h02};
    tbl[4] = '{13'h1FF0, 0, 0, 2, 1, 1'b0, 1'b0,  32, 8'h02};
    tbl[5] = '{13'h000,  1, 2, 0, 0, 1'b1, 1'b0,  64, 8'h04};
    tbl[6] = '{13'h333,  2, 3, 2, 1, 1'b0, 1'b1, 192, 8'h08};

    rst = 1'b0; start_calculate = 1'b0; feature_load_end = 1'b0; w_ready = 1'b0;
    mode = 4'd0; addr_start_w = '0; in_piece = '0; out_piece = '0; addr_bias = 13'h1F00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Wrong mode must not start
    mode = 4'd3; start_calculate = 1'b1;
    @(posedge clk); #1;
    start_calculate = 1'b0;
    check("wrong_mode_busy", 32'(o_busy), 0);

    // Feature pulse in IDLE is not remembered; WAIT_FEAT holds without it
    feature_load_end = 1'b1;
    @(posedge clk); #1;
    feature_load_end = 1'b0;
    addr_start_w = 13'h0A0; in_piece = 8'd2; out_piece = 8'd2; mode = 4'd2;
    start_calculate = 1'b1;
    @(posedge clk); #1;
    start_calculate = 1'b0;
    check("start_busy", 32'(o_busy), 1);
    check("start_pe", 32'(o_pe_en), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wait_hold_rd", 32'(o_rd_en), 0);
      @(posedge clk); #1;
    end
    feature_load_end = 1'b1; w_ready = 1'b1;
    @(posedge clk); #1;
    feature_load_end = 1'b0;
    check("first_rd_en", 32'(o_rd_en), 1);
    check("first_addr", 32'(o_w_addr), 32'h0A0);

    // Reset asserted in ADDR_GEN after ten accepted beats
    acc = 0;
    for (int k = 0; k < 40 && acc < 10; k++) begin
      @(negedge clk);
      if (o_rd_en && w_ready) acc++;
      @(posedge clk); #1;
    end
    check("beats_before_rst", acc, 10);
    check("addr_before_rst", 32'(o_w_addr), 32'h0AA);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int t = 0; t < 7; t++) run_layer(tbl[t]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
